// File: rtl/icache_l1.sv
// Direct-mapped, read-only L1 instruction cache with whole-line burst refill
// and a full-cache invalidate for fence.i.
module icache_l1 #(
    parameter int LINE_COUNT = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] im_req_addr,
    input  logic        im_req_valid,
    output logic [63:0] im_resp_rdata,
    output logic        im_resp_valid,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic [63:0] mem_resp_rdata,
    input  logic        mem_resp_valid,
    input  logic        inv_req,
    output logic        inv_ack
);

    localparam int O = $clog2(8 * LINE_WORDS);
    localparam int I = $clog2(LINE_COUNT);
    localparam int W = $clog2(LINE_WORDS);
    localparam int T = 64 - O - I;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_DATA,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [T-1:0]          tag_q;
    logic [I-1:0]          index_q;
    logic [W-1:0]          wsel_q;
    logic [T-1:0]          tag_mem [LINE_COUNT];
    logic [63:0]           data_mem [LINE_COUNT * LINE_WORDS];
    logic [T-1:0]          tag_rd;
    logic [63:0]           data_rd;
    logic [LINE_COUNT-1:0] valid;
    logic [W-1:0]          beat_cnt;
    logic [63:0]           resp_q;
    logic                  inv_ack_q;

    logic req_fire;
    logic inv_fire;
    logic hit;
    logic beat_fire;
    logic last_beat;
    logic unused;

    assign unused    = &{1'b0, im_req_addr[2:0]};
    assign req_fire  = (state == IDLE) && im_req_valid;
    assign inv_fire  = (state == IDLE) && !im_req_valid && inv_req;
    assign hit       = valid[index_q] && (tag_rd == tag_q);
    assign beat_fire = (state == REFILL_DATA) && mem_resp_valid;
    assign last_beat = beat_fire && (beat_cnt == W'(LINE_WORDS - 1));
    assign inv_ack   = inv_ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch, valid bits, beat counter and critical-word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q     <= '0;
            index_q   <= '0;
            wsel_q    <= '0;
            valid     <= '0;
            beat_cnt  <= '0;
            resp_q    <= '0;
            inv_ack_q <= 1'b0;
        end else begin
            inv_ack_q <= inv_fire;
            if (req_fire) begin
                tag_q   <= im_req_addr[63:O+I];
                index_q <= im_req_addr[O+I-1:O];
                wsel_q  <= im_req_addr[O-1:3];
            end
            if (inv_fire) begin
                valid <= '0;
            end
            if ((state == REFILL_REQ) && mem_req_ready) begin
                beat_cnt <= '0;
            end
            if (beat_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == wsel_q) begin
                    resp_q <= mem_resp_rdata;
                end
            end
            if (last_beat) begin
                valid[index_q] <= 1'b1;
            end
        end
    end

    // Arrays are not reset; read data is registered for the LOOKUP cycle.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_rd  <= tag_mem[im_req_addr[O+I-1:O]];
            data_rd <= data_mem[{im_req_addr[O+I-1:O], im_req_addr[O-1:3]}];
        end
        if (beat_fire) begin
            data_mem[{index_q, beat_cnt}] <= mem_resp_rdata;
        end
        if (last_beat) begin
            tag_mem[index_q] <= tag_q;
        end
    end

    always_comb begin
        state_next    = state;
        im_resp_valid = 1'b0;
        im_resp_rdata = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state)
            IDLE: begin
                if (im_req_valid) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    im_resp_valid = 1'b1;
                    im_resp_rdata = data_rd;
                    state_next    = IDLE;
                end else begin
                    state_next = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, index_q, {O{1'b0}}};
                if (mem_req_ready) begin
                    state_next = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                if (last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                im_resp_valid = 1'b1;
                im_resp_rdata = resp_q;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: a table of fetch transactions with a
// zero-wait/backpressured memory model, plus invalidate and reset sequences.
module tb_icache_l1;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_valid;
    logic        inv_req;
    logic        inv_ack;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [63:0] addr;
        bit          miss;
        logic [63:0] base;
        int          delay;
        bit          gap;
        logic [63:0] exp_maddr;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    icache_l1 #(.LINE_COUNT(64), .LINE_WORDS(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .im_req_addr    (im_req_addr),
        .im_req_valid   (im_req_valid),
        .im_resp_rdata  (im_resp_rdata),
        .im_resp_valid  (im_resp_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_valid (mem_resp_valid),
        .inv_req        (inv_req),
        .inv_ack        (inv_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One fetch; on a miss the bench plays the backing memory, beat k = base + 0x11*k.
    task automatic apply_stimulus(input vec_t v);
        step();
        im_req_addr  = v.addr;
        im_req_valid = 1'b1;
        step();
        im_req_valid = 1'b0;
        im_req_addr  = 64'h0;
        if (!v.miss) begin
            check_output("hit_valid", im_resp_valid, 1);
            check_output("hit_data", im_resp_rdata, v.exp_data);
            check_output("hit_no_mreq", mem_req_valid, 0);
            check_output("hit_no_inv_ack", inv_ack, 0);
        end else begin
            check_output("lookup_no_resp", im_resp_valid, 0);
            check_output("lookup_no_mreq", mem_req_valid, 0);
            step();
            for (int c = 0; c <= v.delay; c++) begin
                check_output("mreq_valid", mem_req_valid, 1);
                check_output("mreq_addr", mem_req_addr, v.exp_maddr);
                check_output("mreq_no_resp", im_resp_valid, 0);
                mem_req_ready = (c == v.delay);
                step();
            end
            mem_req_ready = 1'b0;
            check_output("mreq_drop", mem_req_valid, 0);
            for (int k = 0; k < LW; k++) begin
                if (v.gap && k > 0) begin
                    mem_resp_valid = 1'b0;
                    step();
                    check_output("gap_no_resp", im_resp_valid, 0);
                end
                mem_resp_valid = 1'b1;
                mem_resp_rdata = v.base + 64'h11 * 64'(k);
                step();
                mem_resp_valid = 1'b0;
                if (k < LW - 1) begin
                    check_output("beat_no_resp", im_resp_valid, 0);
                end
            end
            check_output("resp_valid", im_resp_valid, 1);
            check_output("resp_data", im_resp_rdata, v.exp_data);
            check_output("resp_no_inv_ack", inv_ack, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_resp_valid"}, im_resp_valid, 0);
        check_output({tag, "_resp_rdata"}, im_resp_rdata, 0);
        check_output({tag, "_mreq_valid"}, mem_req_valid, 0);
        check_output({tag, "_mreq_addr"}, mem_req_addr, 0);
        check_output({tag, "_inv_ack"}, inv_ack, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs = '{
            '{64'h80000000, 1'b1, 64'h11, 0, 1'b0, 64'h80000000, 64'h11},
            '{64'h80000008, 1'b0, 64'h00, 0, 1'b0, 64'h0,        64'h22},
            '{64'h80000038, 1'b1, 64'h51, 0, 1'b0, 64'h80000020, 64'h84},
            '{64'h8000003C, 1'b0, 64'h00, 0, 1'b0, 64'h0,        64'h84},
            '{64'h80000800, 1'b1, 64'hAA, 0, 1'b0, 64'h80000800, 64'hAA},
            '{64'h80000010, 1'b1, 64'h11, 0, 1'b0, 64'h80000000, 64'h33},
            '{64'h80000808, 1'b1, 64'hAA, 0, 1'b0, 64'h80000800, 64'hBB},
            '{64'h80000030, 1'b0, 64'h00, 0, 1'b0, 64'h0,        64'h73},
            '{64'h80001040, 1'b1, 64'h21, 5, 1'b1, 64'h80001040, 64'h21},
            '{64'h80001058, 1'b0, 64'h00, 0, 1'b0, 64'h0,        64'h54}
        };

        rst            = 1'b1;
        im_req_addr    = 64'h0;
        im_req_valid   = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_rdata = 64'h0;
        mem_resp_valid = 1'b0;
        inv_req        = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Invalidate from IDLE: ack next cycle, single-cycle, all lines cleared.
        step();
        inv_req = 1'b1;
        step();
        check_output("inv_ack", inv_ack, 1);
        inv_req = 1'b0;
        step();
        check_output("inv_ack_pulse", inv_ack, 0);
        apply_stimulus('{64'h80000008, 1'b1, 64'h11, 0, 1'b0, 64'h80000000, 64'h22});
        apply_stimulus('{64'h80001058, 1'b1, 64'h21, 0, 1'b0, 64'h80001040, 64'h54});

        // Invalidate raised alongside a miss: request wins, ack only after RESP.
        inv_req = 1'b1;
        apply_stimulus('{64'h80000820, 1'b1, 64'h61, 0, 1'b0, 64'h80000820, 64'h61});
        step();
        check_output("inv_wait_idle", inv_ack, 0);
        step();
        check_output("inv_ack_after_refill", inv_ack, 1);
        inv_req = 1'b0;
        apply_stimulus('{64'h80000820, 1'b1, 64'h61, 0, 1'b0, 64'h80000820, 64'h61});

        // Reset after two beats of a refill.
        step();
        im_req_addr  = 64'h80000000;
        im_req_valid = 1'b1;
        step();
        im_req_valid = 1'b0;
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hE0;
        step();
        mem_resp_rdata = 64'hE1;
        step();
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        apply_stimulus('{64'h80000000, 1'b1, 64'h11, 0, 1'b0, 64'h80000000, 64'h11});
        apply_stimulus('{64'h80000018, 1'b0, 64'h00, 0, 1'b0, 64'h0, 64'h44});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/icache_l1.md
# icache_l1

Direct-mapped, read-only L1 instruction cache that answers the instruction-fetch pipeline's I-mem port: `im_req_*` in, `im_resp_*` out. On a miss it refills a whole line from the backing memory bus as a fixed-length burst, then replies. It sits between the fetch pipeline and the memory arbiter. It also provides a full-cache invalidate for `fence.i`.

## Interface

Parameters:
- `LINE_COUNT`, default 64: number of lines; must be a power of 2 and ≥ 2.
- `LINE_WORDS`, default 4: 64-bit words per line; must be a power of 2 and ≥ 2. Line size is 8·`LINE_WORDS` bytes.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `im_req_addr` in 64: fetch address; bits [2:0] are ignored.
- `im_req_valid` in 1: request strobe; single-cycle per request.
- `im_resp_rdata` out 64: aligned doubleword containing the addressed instruction.
- `im_resp_valid` out 1: response strobe; exactly one per accepted request.
- `mem_req_addr` out 64: line-aligned refill address.
- `mem_req_valid` out 1: refill request; held until the ready handshake.
- `mem_req_ready` in 1: backing memory accepts the request.
- `mem_resp_rdata` in 64: refill beat data.
- `mem_resp_valid` in 1: refill beat strobe. Beats arrive in order, word 0 first, with gaps allowed.
- `inv_req` in 1: invalidate all lines; held until acknowledged.
- `inv_ack` out 1: single-cycle acknowledge.

## Operation

Address split, with O = log2(8·`LINE_WORDS`) and I = log2(`LINE_COUNT`):
- offset = addr[O-1:0]
- word select = addr[O-1:3]
- index = addr[O+I-1:O]
- tag = addr[63:O+I]

Storage:
- Tag and data arrays use synchronous read.
- Valid bits are flops, one per line.

Protocol assumption: the requester has at most one request outstanding. An `im_req_valid` asserted while not in IDLE is a protocol violation. It is ignored and no response is produced for it.

States:
- **IDLE**
  - On `im_req_valid`: latch addr, read tag/data arrays, go to LOOKUP.
  - Else, on `inv_req`: clear all valid bits, pulse `inv_ack`, stay in IDLE.
- **LOOKUP**
  - Hit (valid[index] && tag match): drive `im_resp_valid`=1 with the array word; go to IDLE.
  - Miss: go to REFILL_REQ.
- **REFILL_REQ**
  - `mem_req_valid`=1, `mem_req_addr` = latched addr with bits [O-1:0] zeroed.
  - On `mem_req_ready`: go to REFILL_DATA with beat counter = 0.
- **REFILL_DATA**
  - Each `mem_resp_valid`: write the beat to data[index][counter]; capture the beat into the response register if counter == word select; counter++.
  - On the final beat (counter == `LINE_WORDS`-1): write the tag, set valid[index], go to RESP.
- **RESP**
  - `im_resp_valid`=1, `im_resp_rdata` = captured word; go to IDLE.

Rules:
- A miss evicts the indexed line unconditionally. No write-back is needed: the cache is read-only.
- `inv_req` is sampled only in IDLE with no concurrent `im_req_valid`. If both are asserted in IDLE, the request wins and the invalidate waits. A refill in progress completes and its line is marked valid; the invalidate that follows clears it.
- `im_resp_rdata` is don't-care when `im_resp_valid`=0.
- The beat counter is log2(`LINE_WORDS`) bits wide and wraps to 0 after the final beat.

## Timing

Reset values:
- All outputs are 0 after reset: `im_resp_valid`, `mem_req_valid`, `inv_ack`, and the address/data outputs.
- State = IDLE, all valid bits = 0.
- Array contents are not reset.

Latencies:
- Hit: request in cycle N, `im_resp_valid` in cycle N+1.
- Miss with zero-wait memory (ready in cycle N+2, beats in cycles N+3..N+2+`LINE_WORDS`):
  - `mem_req_valid` is high from cycle N+2.
  - Response comes 1 cycle after the final beat, i.e. N+3+`LINE_WORDS` (N+7 at defaults).
- `mem_req_valid` stays high with a stable `mem_req_addr` until it is sampled together with `mem_req_ready`=1. It deasserts the following cycle.
- `inv_ack` is asserted in the cycle after `inv_req` is sampled in IDLE. The cache accepts requests again from that same cycle.
- Reset mid-refill: the FSM returns to IDLE, all lines are invalidated, and no response is produced. The backing memory shares `rst` and drops its outstanding burst.

## Test plan

1. **Cold miss then hit.** After reset, request 0x80000000; issue `mem_req_ready` immediately and beats D0..D3 = 0x11..0x44 back-to-back.
   - `mem_req_addr`=0x80000000.
   - `im_resp_valid` at cycle N+7 with data 0x11.
   - A following request to 0x80000008 returns 0x22 one cycle later, with no `mem_req_valid`.
2. **Critical word not first.** Cold request to 0x80000018 → refill from 0x80000000; response = D3.
3. **Conflict eviction.** After scenario 1, request 0x80000800 (same index 0, different tag) → miss. Refill with 0xAA..0xDD returns 0xAA. A subsequent request to 0x80000000 misses again.
4. **Backpressure and gaps.** Hold `mem_req_ready`=0 for 5 cycles and insert 1-cycle gaps between beats.
   - `mem_req_valid` and `mem_req_addr` stay stable throughout.
   - Exactly 4 beats are consumed and one response is produced.
5. **Invalidate.** After scenario 1, pulse `inv_req` → `inv_ack` next cycle. Request 0x80000000 now misses. Separately: `inv_req` asserted during a refill is acknowledged only after RESP, and the refilled line is invalid afterwards.
6. **Reset mid-refill.** Assert `rst` after 2 beats → all outputs 0 the next cycle. Request 0x80000000 then misses.
